// File: rtl/mcif_rd_nport_pkg.sv
// Shared constants for the multi-port AXI read command interface.
// Burst, credit and data-width defaults used by every mcif_rd_nport build.
package mcif_rd_nport_pkg;

    localparam int MAX_DAT_DW         = 8;
    localparam int MAX_LOG2_DAT_DW    = 3;
    localparam int TOUT               = 8;
    localparam int LOG2_TOUT          = 3;
    localparam int LOG2_AXI_BURST_LEN = 4;
    localparam int MCIF_RD_CREDIT_NUM = 16;

    localparam int RD_DATA_W = MAX_DAT_DW * TOUT;
    localparam int AR_SIZE   = MAX_LOG2_DAT_DW + LOG2_TOUT - 3;

    localparam logic [1:0] AR_BURST_INCR = 2'b01;
    localparam logic [3:0] AR_CACHE_MOD  = 4'b0010;

    // Byte address of a client request: base plus offset, wrapping at 4 GiB.
    function automatic logic [31:0] req_addr(input logic [31:0] base,
                                             input logic [31:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/hs_fifo.sv
// Valid/ready command FIFO with registered ready.
// Ready stays low during and for one cycle after reset.
module hs_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_pd,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_pd
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             open_q, open_d;
    logic             push, pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_rdy  = open_q & (cnt_q != CW'(DEPTH));
    assign out_vld = (cnt_q != '0);
    assign out_pd  = mem_q[rp_q];
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    // Pointer, occupancy and storage update.
    always_comb begin
        mem_d  = mem_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        open_d = 1'b1;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wp_q] = in_pd;
            wp_d        = nxt(wp_q);
        end
        if (pop) begin
            rp_d = nxt(rp_q);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            open_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            open_q <= open_d;
        end
    end

endmodule

// File: rtl/mcif_rr_arbn.sv
// N-way round-robin arbiter; pointer advances past the winner on grant.
// en gates the grant so the pointer only moves when a grant is taken.
module mcif_rr_arbn #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    // Search from the priority pointer for the first requester.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N]) begin
                found   = 1'b1;
                gnt_idx = IW'((int'(ptr_q) + k) % N);
            end
        end
        gnt_vld = found & en;
        gnt     = gnt_vld ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
        ptr_d   = ptr_q;
        if (gnt_vld) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mcif_rd_nport.sv
// Multi-port AXI read master: per-port command FIFOs, credit and
// outstanding tracking, round-robin AR issue and RID-based R routing.
module mcif_rd_nport
    import mcif_rd_nport_pkg::*;
#(
    parameter int NUM_PORTS        = 4,
    parameter int M_AXI_ID_WIDTH   = 4,
    parameter int M_AXI_DATA_WIDTH = RD_DATA_W,
    parameter int LEN_W            = LOG2_AXI_BURST_LEN,
    parameter int CMD_FIFO_DEPTH   = 4,
    parameter int CREDIT_NUM       = MCIF_RD_CREDIT_NUM,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            rd_req_vld,
    output logic [NUM_PORTS-1:0]            rd_req_rdy,
    input  logic [NUM_PORTS*(LEN_W+64)-1:0] rd_req_pd,
    output logic [NUM_PORTS-1:0]            rd_resp_vld,
    output logic [NUM_PORTS-1:0]            rd_resp_last,
    input  logic [NUM_PORTS-1:0]            rd_resp_rdy,
    output logic [M_AXI_DATA_WIDTH-1:0]     rd_resp_pd,
    input  logic [NUM_PORTS-1:0]            rd_fifo_pop,
    output logic [M_AXI_ID_WIDTH-1:0]       m_axi_arid,
    output logic [31:0]                     m_axi_araddr,
    output logic [LEN_W-1:0]                m_axi_arlen,
    output logic [2:0]                      m_axi_arsize,
    output logic [1:0]                      m_axi_arburst,
    output logic                            m_axi_arlock,
    output logic [3:0]                      m_axi_arcache,
    output logic [2:0]                      m_axi_arprot,
    output logic [3:0]                      m_axi_arqos,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [M_AXI_ID_WIDTH-1:0]       m_axi_rid,
    input  logic [M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rlast,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    output logic                            rid_err
);

    localparam int PD_W = LEN_W + 64;
    localparam int CW   = $clog2(CREDIT_NUM) + 1;
    localparam int CS   = CW + 1;
    localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW   = $clog2(NUM_PORTS);

    logic [NUM_PORTS*PD_W-1:0] head_flat;
    logic [NUM_PORTS-1:0]      head_vld, elig, pop;
    logic                      grant, ar_free, rid_ok;
    logic [IW-1:0]             gidx;
    logic [PD_W-1:0]           win_pd;

    logic                      arvalid_q, arvalid_d;
    logic [M_AXI_ID_WIDTH-1:0] arid_q, arid_d;
    logic [31:0]               araddr_q, araddr_d;
    logic [LEN_W-1:0]          arlen_q, arlen_d;
    logic                      rid_err_q, rid_err_d;
    logic                      unused_rresp;

    assign ar_free = ~arvalid_q | m_axi_arready;
    assign rid_ok  = (m_axi_rid < M_AXI_ID_WIDTH'(NUM_PORTS));
    assign win_pd  = head_flat[int'(gidx)*PD_W +: PD_W];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [LEN_W-1:0] len;
        logic [CW-1:0]    credit_q, credit_d;
        logic [OW-1:0]    out_q, out_d;
        logic [CS-1:0]    cr_sum;
        logic             r_done;

        hs_fifo #(
            .WIDTH (PD_W),
            .DEPTH (CMD_FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .in_vld  (rd_req_vld[g]),
            .in_rdy  (rd_req_rdy[g]),
            .in_pd   (rd_req_pd[g*PD_W +: PD_W]),
            .out_vld (head_vld[g]),
            .out_rdy (pop[g]),
            .out_pd  (head_flat[g*PD_W +: PD_W])
        );

        assign len    = head_flat[g*PD_W + PD_W - 1 -: LEN_W];
        assign r_done = rd_resp_vld[g] & m_axi_rready & m_axi_rlast;
        assign elig[g] = head_vld[g]
                       & (int'(len) < int'(credit_q))
                       & (int'(out_q) < MAX_OUTSTANDING);

        // Credit and in-flight burst accounting for this port.
        always_comb begin
            cr_sum = {1'b0, credit_q} + CS'(rd_fifo_pop[g]);
            if (pop[g]) begin
                cr_sum = cr_sum - CS'(len) - 1'b1;
            end
            credit_d = (cr_sum > CS'(CREDIT_NUM)) ? CW'(CREDIT_NUM)
                                                 : cr_sum[CW-1:0];
            out_d = out_q;
            if (pop[g] && !r_done) begin
                out_d = out_q + 1'b1;
            end else if (!pop[g] && r_done && out_q != '0) begin
                out_d = out_q - 1'b1;
            end
        end

        // Per-port counters.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                credit_q <= CW'(CREDIT_NUM);
                out_q    <= '0;
            end else begin
                credit_q <= credit_d;
                out_q    <= out_d;
            end
        end
    end

    mcif_rr_arbn #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (elig),
        .en      (ar_free),
        .gnt     (pop),
        .gnt_vld (grant),
        .gnt_idx (gidx)
    );

    // AR output register: load on grant, hold until handshake.
    always_comb begin
        arvalid_d = arvalid_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        rid_err_d = rid_err_q | (m_axi_rvalid & ~rid_ok);
        if (grant) begin
            arvalid_d = 1'b1;
            arid_d    = M_AXI_ID_WIDTH'(gidx);
            araddr_d  = req_addr(win_pd[63:32], win_pd[31:0]);
            arlen_d   = win_pd[PD_W-1 -: LEN_W];
        end else if (m_axi_arready) begin
            arvalid_d = 1'b0;
        end
    end

    // AR and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            rid_err_q <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            rid_err_q <= rid_err_d;
        end
    end

    // R routing by RID; out-of-range beats are accepted and dropped.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_resp_vld[i]  = m_axi_rvalid & (m_axi_rid == M_AXI_ID_WIDTH'(i));
            rd_resp_last[i] = rd_resp_vld[i] & m_axi_rlast;
        end
        m_axi_rready = rid_ok ? rd_resp_rdy[m_axi_rid[IW-1:0]] : 1'b1;
    end

    assign unused_rresp  = ^m_axi_rresp;
    assign rd_resp_pd    = m_axi_rdata;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(AR_SIZE);
    assign m_axi_arburst = AR_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AR_CACHE_MOD;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign rid_err       = rid_err_q;

endmodule
